// File: rtl/idct_pkg.sv
// Shared constants, state encoding and output rounding for the 16-point inverse DCT-II pass.
package idct_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Indexed [k][m]: the even entry is T16[2m][k] and the odd entry is T16[2m+1][k]
  localparam logic signed [7:0] T16_EVEN [8][8] = '{
    '{8'sd64,  8'sd89,  8'sd83,  8'sd75,  8'sd64,  8'sd50,  8'sd36,  8'sd18},
    '{8'sd64,  8'sd75,  8'sd36, -8'sd18, -8'sd64, -8'sd89, -8'sd83, -8'sd50},
    '{8'sd64,  8'sd50, -8'sd36, -8'sd89, -8'sd64,  8'sd18,  8'sd83,  8'sd75},
    '{8'sd64,  8'sd18, -8'sd83, -8'sd50,  8'sd64,  8'sd75, -8'sd36, -8'sd89},
    '{8'sd64, -8'sd18, -8'sd83,  8'sd50,  8'sd64, -8'sd75, -8'sd36,  8'sd89},
    '{8'sd64, -8'sd50, -8'sd36,  8'sd89, -8'sd64, -8'sd18,  8'sd83, -8'sd75},
    '{8'sd64, -8'sd75,  8'sd36,  8'sd18, -8'sd64,  8'sd89, -8'sd83,  8'sd50},
    '{8'sd64, -8'sd89,  8'sd83, -8'sd75,  8'sd64, -8'sd50,  8'sd36, -8'sd18}
  };

  localparam logic signed [7:0] T16_ODD [8][8] = '{
    '{8'sd90,  8'sd87,  8'sd80,  8'sd70,  8'sd57,  8'sd43,  8'sd25,  8'sd9},
    '{8'sd87,  8'sd57,  8'sd9,  -8'sd43, -8'sd80, -8'sd90, -8'sd70, -8'sd25},
    '{8'sd80,  8'sd9,  -8'sd70, -8'sd87, -8'sd25,  8'sd57,  8'sd90,  8'sd43},
    '{8'sd70, -8'sd43, -8'sd87,  8'sd9,   8'sd90,  8'sd25, -8'sd80, -8'sd57},
    '{8'sd57, -8'sd80, -8'sd25,  8'sd90, -8'sd9,  -8'sd87,  8'sd43,  8'sd70},
    '{8'sd43, -8'sd90,  8'sd57,  8'sd25, -8'sd87,  8'sd70,  8'sd9,  -8'sd80},
    '{8'sd25, -8'sd70,  8'sd90, -8'sd80,  8'sd43,  8'sd9,  -8'sd57,  8'sd87},
    '{8'sd9,  -8'sd25,  8'sd43, -8'sd57,  8'sd70, -8'sd80,  8'sd87, -8'sd90}
  };

  function automatic logic signed [31:0] round_clip(input logic signed [63:0] acc,
                                                    input int shift, input int out_w);
    logic signed [63:0] r, hi, lo;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r[31:0];
  endfunction

endpackage

// File: rtl/idct_mac8.sv
// Combinational 8-term signed dot product of coefficients and transform constants.
module idct_mac8 #(
  parameter int IN_W  = 16,
  parameter int ACC_W = IN_W + 12
) (
  input  logic signed [IN_W-1:0]  x [8],
  input  logic signed [7:0]       c [8],
  output logic signed [ACC_W-1:0] acc
);

  always_comb begin
    acc = '0;
    for (int m = 0; m < 8; m++) begin
      acc = acc + ACC_W'(x[m]) * ACC_W'(c[m]);
    end
  end

endmodule

// File: rtl/idct2_16_seq.sv
// Sequential 16-point inverse DCT-II, one even/odd output pair per cycle.
// Optional macro IDCT_ZERO_SKIP_EN: an all-zero vector bypasses CALC and finishes on the accept edge.
module idct2_16_seq
  import idct_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_coef [16],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data [16]
);

  localparam int ACC_W = IN_W + 12;

  state_t                  state_p0, state_nxt;
  logic [2:0]              k_p0;
  logic signed [IN_W-1:0]  coef_p0 [16];
  logic signed [IN_W-1:0]  x_even [8];
  logic signed [IN_W-1:0]  x_odd [8];
  logic signed [7:0]       c_even [8];
  logic signed [7:0]       c_odd [8];
  logic signed [ACC_W-1:0] acc_even, acc_odd, y_sum, y_diff;
  logic [3:0]              idx_lo, idx_hi;
  logic                    accept, release_hs;

  always_comb begin
    for (int m = 0; m < 8; m++) begin
      x_even[m] = coef_p0[2*m];
      x_odd[m]  = coef_p0[2*m+1];
      c_even[m] = T16_EVEN[k_p0][m];
      c_odd[m]  = T16_ODD[k_p0][m];
    end
  end

  idct_mac8 #(.IN_W(IN_W), .ACC_W(ACC_W)) u_mac_even (.x(x_even), .c(c_even), .acc(acc_even));
  idct_mac8 #(.IN_W(IN_W), .ACC_W(ACC_W)) u_mac_odd  (.x(x_odd),  .c(c_odd),  .acc(acc_odd));

  assign y_sum      = acc_even + acc_odd;
  assign y_diff     = acc_even - acc_odd;
  assign idx_lo     = {1'b0, k_p0};
  assign idx_hi     = 4'd15 - idx_lo;
  // in_ready is held low while reset is asserted, not just after it
  assign in_ready   = rst_n && (state_p0 == IDLE);
  assign out_valid  = (state_p0 == DONE);
  assign accept     = in_valid && in_ready;
  assign release_hs = out_valid && out_ready;

`ifdef IDCT_ZERO_SKIP_EN
  logic all_zero;
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (in_coef[i] != '0) all_zero = 1'b0;
    end
  end
`endif

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE: begin
        if (accept) begin
`ifdef IDCT_ZERO_SKIP_EN
          state_nxt = all_zero ? DONE : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (k_p0 == 3'd7) state_nxt = DONE;
      DONE:    if (release_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control stage: state and column counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      k_p0     <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (accept) k_p0 <= '0;
      else if (state_p0 == CALC) k_p0 <= k_p0 + 3'd1;
    end
  end

  // Data stage: coefficient capture and symmetric output pair write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_p0  <= '{default: '0};
      out_data <= '{default: '0};
    end else begin
      if (accept) coef_p0 <= in_coef;
`ifdef IDCT_ZERO_SKIP_EN
      if (accept && all_zero) out_data <= '{default: '0};
`endif
      if (state_p0 == CALC) begin
        out_data[idx_lo] <= OUT_W'(round_clip(64'(y_sum), SHIFT, OUT_W));
        out_data[idx_hi] <= OUT_W'(round_clip(64'(y_diff), SHIFT, OUT_W));
      end
    end
  end

endmodule

// File: tb/tb_idct2_16_seq.sv
// Self-checking bench for idct2_16_seq: table-driven vectors against a full-matrix reference model.
module tb_idct2_16_seq;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int SHIFT = 7;
`ifdef IDCT_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 9;
`endif

  typedef logic signed [IN_W-1:0]  vec_t  [16];
  typedef logic signed [OUT_W-1:0] ovec_t [16];
  typedef struct { ovec_t y; } exp_t;
  typedef struct { string name; vec_t coef; int lat; } rec_t;

  // First 8 columns of each T16 row; the rest follow from even/odd row symmetry
  localparam int T8 [16][8] = '{
    '{64, 64, 64, 64, 64, 64, 64, 64},
    '{90, 87, 80, 70, 57, 43, 25, 9},
    '{89, 75, 50, 18, -18, -50, -75, -89},
    '{87, 57, 9, -43, -80, -90, -70, -25},
    '{83, 36, -36, -83, -83, -36, 36, 83},
    '{80, 9, -70, -87, -25, 57, 90, 43},
    '{75, -18, -89, -50, 50, 89, 18, -75},
    '{70, -43, -87, 9, 90, 25, -80, -57},
    '{64, -64, -64, 64, 64, -64, -64, 64},
    '{57, -80, -25, 90, -9, -87, 43, 70},
    '{50, -89, 18, 75, -75, -18, 89, -50},
    '{43, -90, 57, 25, -87, 70, 9, -80},
    '{36, -83, 83, -36, -36, 83, -83, 36},
    '{25, -70, 90, -80, 43, 9, -57, 87},
    '{18, -50, 75, -89, 89, -75, 50, -18},
    '{9, -25, 43, -57, 70, -80, 87, -90}
  };

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [IN_W-1:0]  in_coef [16];
  logic signed [OUT_W-1:0] out_data [16];

  int    n_chk = 0;
  int    n_fail = 0;
  exp_t  exp_q [$];
  rec_t  tbl [8];

  always #5 clk = ~clk;

  idct2_16_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int t16(input int k, input int n);
    if (n < 8) return T8[k][n];
    return (k % 2 == 0) ? T8[k][15-n] : -T8[k][15-n];
  endfunction

  task automatic model(input vec_t x, output ovec_t y);
    longint acc, r, hi, lo;
    hi = (64'sd1 <<< (OUT_W - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_W - 1));
    for (int n = 0; n < 16; n++) begin
      acc = 0;
      for (int k = 0; k < 16; k++) acc += longint'(t16(k, n)) * longint'(x[k]);
      r = (acc + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      y[n] = OUT_W'(r);
    end
  endtask

  task automatic drive(input vec_t c);
    exp_t e;
    int   guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    chk("in_ready before accept", in_ready, 1);
    in_coef  = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(c, e.y);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string nm, input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({nm, " latency"}, lat, exp_lat);
  endtask

  task automatic check_data(input string nm, input ovec_t y);
    for (int i = 0; i < 16; i++) chk($sformatf("%s Y[%0d]", nm, i), out_data[i], y[i]);
  endtask

  task automatic collect(input string nm, input int exp_lat);
    exp_t e;
    wait_valid(nm, exp_lat);
    chk({nm, " queued"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_data(nm, e.y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, " out_valid after release"}, out_valid, 0);
    chk({nm, " in_ready after release"}, in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 16; i++) in_coef[i] = '0;
    for (int t = 0; t < 8; t++) begin
      tbl[t].lat = 9;
      for (int i = 0; i < 16; i++) tbl[t].coef[i] = '0;
    end
    tbl[0].name = "dc64";    tbl[0].coef[0] = 16'sd64;
    tbl[1].name = "x1_128";  tbl[1].coef[1] = 16'sd128;
    tbl[2].name = "allmax";
    tbl[3].name = "allmin";
    tbl[4].name = "zero";    tbl[4].lat = ZLAT;
    tbl[5].name = "alt";
    tbl[6].name = "rnd_small";
    tbl[7].name = "rnd_full";
    for (int i = 0; i < 16; i++) begin
      tbl[2].coef[i] = 16'sh7fff;
      tbl[3].coef[i] = -16'sh8000;
      tbl[5].coef[i] = (i % 2 == 0) ? 16'sd20000 : -16'sd20000;
      tbl[6].coef[i] = IN_W'(int'($urandom_range(0, 4095)) - 2048);
      tbl[7].coef[i] = IN_W'($urandom);
    end

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    for (int i = 0; i < 16; i++) chk($sformatf("reset out_data[%0d]", i), out_data[i], 0);
    rst_n = 1'b1; #1;
    chk("post-reset in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].coef);
      collect(tbl[t].name, tbl[t].lat);
      if (t == 0) begin
        for (int i = 0; i < 16; i++) chk($sformatf("dc64 const Y[%0d]", i), out_data[i], 32);
      end else if (t == 1) begin
        chk("x1 Y0", out_data[0], 90);   chk("x1 Y15", out_data[15], -90);
        chk("x1 Y7", out_data[7], 9);    chk("x1 Y8", out_data[8], -9);
        chk("x1 Y1", out_data[1], 87);   chk("x1 Y14", out_data[14], -87);
      end else if (t == 2) begin
        chk("allmax Y0 clip", out_data[0], 32767);
        chk("allmax Y15", out_data[15], 4608);
      end else if (t == 4) begin
        for (int i = 0; i < 16; i++) chk($sformatf("zero const Y[%0d]", i), out_data[i], 0);
      end
    end

    // Backpressure in DONE, ignored input pulses, then back-to-back accept
    drive(tbl[6].coef);
    wait_valid("bp", 9);
    chk("bp queued", exp_q.size(), 1);
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      in_coef  = tbl[1].coef;
      @(posedge clk); #1;
      chk($sformatf("bp hold %0d out_valid", c), out_valid, 1);
      chk($sformatf("bp hold %0d in_ready", c), in_ready, 0);
      check_data($sformatf("bp hold %0d", c), e.y);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    drive(tbl[0].coef);
    collect("b2b", 9);
    for (int i = 0; i < 16; i++) chk($sformatf("b2b const Y[%0d]", i), out_data[i], 32);

    // Reset in the middle of CALC at k=4
    drive(tbl[5].coef);
    repeat (4) @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset in_ready", in_ready, 0);
    exp_q.delete();
    #2 rst_n = 1'b1; #1;
    chk("midreset release in_ready", in_ready, 1);
    chk("midreset release out_valid", out_valid, 0);
    drive(tbl[0].coef);
    collect("post_reset", 9);
    for (int i = 0; i < 16; i++) chk($sformatf("post_reset const Y[%0d]", i), out_data[i], 32);

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
